// File: rtl/text_line_fetch_pkg.sv
// Shared memory map, text geometry and fetch FSM encoding for the text line fetcher.
// Address helpers wrap naturally modulo the 13-bit memory space.
package text_line_fetch_pkg;

    localparam int MEM_AW = 13;
    localparam int MEM_DW = 8;

    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int FONT_H = 16;

    localparam logic [MEM_AW-1:0] SCREEN_BASE = 13'h1000;
    localparam logic [MEM_AW-1:0] FONT_BASE   = 13'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_CHAR,
        ST_WAIT_CHAR,
        ST_RD_FONT,
        ST_WAIT_FONT,
        ST_EMIT,
        ST_DONE
    } state_t;

    function automatic logic [MEM_AW-1:0] screen_addr(input logic [4:0] row, input logic [6:0] col);
        return SCREEN_BASE + 13'(row) * 13'(COLS) + 13'(col);
    endfunction

    function automatic logic [MEM_AW-1:0] font_addr(input logic [7:0] code, input logic [3:0] scan);
        return FONT_BASE + 13'(code) * 13'(FONT_H) + 13'(scan);
    endfunction

endpackage

// File: rtl/text_line_fetch.sv
// Walks one scanline of a text row: char code read, font byte read, emit per column.
// Latency: 5 cycles per column with ready high, o_done 400 cycles after accepted start.
// Backpressure: EMIT holds the font byte until i_pix_ready; no memory request during a stall.
module text_line_fetch
    import text_line_fetch_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [4:0]        i_row,
    input  logic [3:0]        i_scan,
    output logic              o_busy,
    output logic              o_done,
    output logic [MEM_AW-1:0] o_addr,
    output logic [MEM_DW-1:0] o_dat,
    output logic              o_we,
    output logic              o_cs,
    input  logic [MEM_DW-1:0] i_dat,
    input  logic              i_ack,
    output logic [7:0]        o_pix_dat,
    output logic [6:0]        o_pix_col,
    output logic              o_pix_valid,
    input  logic              i_pix_ready
);

    localparam logic [6:0] LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0] ROW_LIMIT = 5'(ROWS);

    state_t     state;
    logic [4:0] row;
    logic [3:0] scan;
    logic [6:0] col;

    // Read-only initiator.
    assign o_dat = '0;
    assign o_we  = 1'b0;

    // o_cs/o_addr are loaded on the edge entering a RD_* state, so they are pure registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            row         <= '0;
            scan        <= '0;
            col         <= '0;
            o_cs        <= 1'b0;
            o_addr      <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pix_dat   <= '0;
            o_pix_col   <= '0;
            o_pix_valid <= 1'b0;
        end else begin
            o_cs   <= 1'b0;
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        row  <= i_row;
                        scan <= i_scan;
                        col  <= '0;
                        if (i_row >= ROW_LIMIT) begin
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state  <= ST_RD_CHAR;
                            o_busy <= 1'b1;
                            o_cs   <= 1'b1;
                            o_addr <= screen_addr(i_row, 7'd0);
                        end
                    end
                end
                ST_RD_CHAR: state <= ST_WAIT_CHAR;
                ST_WAIT_CHAR: begin
                    if (i_ack) begin
                        state  <= ST_RD_FONT;
                        o_cs   <= 1'b1;
                        o_addr <= font_addr(i_dat, scan);
                    end
                end
                ST_RD_FONT: state <= ST_WAIT_FONT;
                ST_WAIT_FONT: begin
                    if (i_ack) begin
                        state       <= ST_EMIT;
                        o_pix_dat   <= i_dat;
                        o_pix_col   <= col;
                        o_pix_valid <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (i_pix_ready) begin
                        o_pix_valid <= 1'b0;
                        if (col == LAST_COL) begin
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                        end else begin
                            col    <= col + 7'd1;
                            state  <= ST_RD_CHAR;
                            o_cs   <= 1'b1;
                            o_addr <= screen_addr(row, col + 7'd1);
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_line_fetch.sv
// Bench for text_line_fetch: behavioural memory responder plus a per-line reference
// computed from screen/font contents, compared against observed requests and outputs.
module tb_text_line_fetch;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic [4:0]  i_row = '0;
    logic [3:0]  i_scan = '0;
    logic        o_busy, o_done, o_we, o_cs, o_pix_valid;
    logic [12:0] o_addr;
    logic [7:0]  o_dat, o_pix_dat;
    logic [6:0]  o_pix_col;
    logic [7:0]  i_dat = '0;
    logic        i_ack = 1'b0;
    logic        i_pix_ready = 1'b1;

    text_line_fetch dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_row(i_row), .i_scan(i_scan),
        .o_busy(o_busy), .o_done(o_done), .o_addr(o_addr), .o_dat(o_dat), .o_we(o_we),
        .o_cs(o_cs), .i_dat(i_dat), .i_ack(i_ack), .o_pix_dat(o_pix_dat),
        .o_pix_col(o_pix_col), .o_pix_valid(o_pix_valid), .i_pix_ready(i_pix_ready)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0]  mem [8192];
    logic [12:0] cs_q [$];
    logic [14:0] pix_q [$];
    int          done_q [$];

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    bit          pend = 0;
    int          pend_cnt = 0;
    logic [12:0] pend_addr = '0;
    bit          late_ack = 0;
    bit          rnd_mode = 0;
    bit          stall_en = 0;
    bit          stall_done = 0;
    int          stall_cnt = 0;
    bit          prev_vld = 0;
    bit          prev_rdy = 1;
    logic [7:0]  prev_dat = '0;
    logic [6:0]  prev_col = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: observe outputs at the falling edge, then drive memory and sink inputs.
    task automatic step();
        @(negedge i_clk);
        cyc++;
        if (o_cs) begin
            chk("cs_while_outstanding", 32'(pend), 32'd0);
            cs_q.push_back(o_addr);
        end
        if (prev_vld && !prev_rdy && !i_reset) begin
            chk("stall_vld", 32'(o_pix_valid), 32'd1);
            chk("stall_dat", 32'(o_pix_dat), 32'(prev_dat));
            chk("stall_col", 32'(o_pix_col), 32'(prev_col));
            chk("stall_cs", 32'(o_cs), 32'd0);
        end
        if (o_done) begin
            done_q.push_back(cyc);
            chk("busy_at_done", 32'(o_busy), 32'd0);
        end
        i_ack = 1'b0;
        i_dat = 8'($urandom);
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                i_ack = 1'b1;
                i_dat = mem[pend_addr];
                pend  = 0;
            end
        end
        if (o_cs) begin
            pend      = 1;
            pend_addr = o_addr;
            pend_cnt  = late_ack ? 3 : (rnd_mode ? int'($urandom_range(1, 3)) : 1);
            late_ack  = 0;
        end
        if (stall_en && !stall_done && o_pix_valid && o_pix_col == 7'd5) begin
            stall_cnt  = 10;
            stall_done = 1;
        end
        if (stall_cnt > 0) begin
            i_pix_ready = 1'b0;
            stall_cnt--;
        end else begin
            i_pix_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (o_pix_valid && i_pix_ready)
            pix_q.push_back({o_pix_col, o_pix_dat});
        prev_vld = o_pix_valid;
        prev_rdy = i_pix_ready;
        prev_dat = o_pix_dat;
        prev_col = o_pix_col;
    endtask

    task automatic clear_obs();
        cs_q.delete();
        pix_q.delete();
        done_q.delete();
    endtask

    // Run one scanline request and compare against the reference built from mem[].
    task automatic run_line(input int row, input int scan, input bit rnd, input bit stall, input bit poke);
        int c0;
        int k;
        int n;
        int sa;
        int fa;
        int code;
        logic [12:0] exp_cs [$];
        logic [14:0] exp_pix [$];
        clear_obs();
        rnd_mode   = rnd;
        stall_en   = stall;
        stall_done = 0;
        i_row   = 5'(row);
        i_scan  = 4'(scan);
        i_start = 1'b1;
        c0 = cyc;
        step();
        i_start = 1'b0;
        k = 0;
        while (done_q.size() == 0 && k < 4000) begin
            if (poke) begin
                i_start = (k % 37 == 5);
                i_row   = 5'($urandom);
                i_scan  = 4'($urandom);
            end
            step();
            k++;
        end
        i_start = 1'b0;
        chk("done_seen", 32'(done_q.size() != 0), 32'd1);
        repeat (3) step();
        chk("done_count", 32'(done_q.size()), 32'd1);

        n = (row < 30) ? 80 : 0;
        if (done_q.size() != 0 && !rnd)
            chk("done_latency", 32'(done_q[0] - c0), (n == 0) ? 32'd1 : 32'(401 + (stall ? 10 : 0)));
        for (int col = 0; col < n; col++) begin
            sa   = (4096 + row * 80 + col) % 8192;
            code = int'(mem[sa]);
            fa   = (code * 16 + scan) % 8192;
            exp_cs.push_back(13'(sa));
            exp_cs.push_back(13'(fa));
            exp_pix.push_back({7'(col), mem[fa]});
        end
        chk("cs_count", 32'(cs_q.size()), 32'(exp_cs.size()));
        chk("pix_count", 32'(pix_q.size()), 32'(exp_pix.size()));
        for (int i = 0; i < cs_q.size() && i < exp_cs.size(); i++)
            chk("cs_addr", 32'(cs_q[i]), 32'(exp_cs[i]));
        for (int i = 0; i < pix_q.size() && i < exp_pix.size(); i++)
            chk("pix_col_dat", 32'(pix_q[i]), 32'(exp_pix[i]));
    endtask

    initial begin
        int k;
        int n0;
        int p0;
        for (int a = 0; a < 8192; a++) mem[a] = 8'($urandom);

        repeat (3) step();
        chk("rst_cs", 32'(o_cs), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_valid", 32'(o_pix_valid), 32'd0);
        chk("rst_addr", 32'(o_addr), 32'd0);
        chk("rst_pix", 32'({o_pix_col, o_pix_dat}), 32'd0);
        chk("we_dat", 32'({o_we, o_dat}), 32'd0);
        i_reset = 1'b0;
        step();

        // Basic fetch with fixed contents.
        mem[13'h1000] = 8'h41;
        mem[13'h0413] = 8'hA5;
        run_line(0, 3, 0, 0, 0);
        chk("basic_addr0", cs_q.size() > 0 ? 32'(cs_q[0]) : 32'hFFFF_FFFF, 32'h1000);
        chk("basic_addr1", cs_q.size() > 1 ? 32'(cs_q[1]) : 32'hFFFF_FFFF, 32'h0413);
        chk("basic_pix0", pix_q.size() > 0 ? 32'(pix_q[0]) : 32'hFFFF_FFFF, 32'h00A5);

        // Last row, last scanline.
        run_line(29, 15, 0, 0, 0);
        chk("row29_addr0", cs_q.size() > 0 ? 32'(cs_q[0]) : 32'hFFFF_FFFF, 32'h1910);

        // Glyph 0xFF at scanline 15 reaches the top of the font area.
        mem[13'h10A0] = 8'hFF;
        run_line(2, 15, 0, 0, 0);
        chk("glyph_top", cs_q.size() > 1 ? 32'(cs_q[1]) : 32'hFFFF_FFFF, 32'h0FFF);

        run_line(5, 7, 0, 1, 0);       // 10-cycle stall at column 5
        run_line(12, 6, 0, 0, 1);      // starts while busy must be ignored
        run_line(30, 4, 0, 0, 0);      // out-of-range row

        // Reset while waiting for the font byte of column 40; its ack arrives late.
        clear_obs();
        rnd_mode = 0;
        stall_en = 0;
        i_row   = 5'd7;
        i_scan  = 4'd9;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        k = 0;
        while (cs_q.size() < 81 && k < 2000) begin step(); k++; end
        late_ack = 1;
        while (cs_q.size() < 82 && k < 2000) begin step(); k++; end
        chk("rst_mid_reached", 32'(cs_q.size()), 32'd82);
        step();
        i_reset = 1'b1;
        step();
        chk("mid_rst_cs", 32'(o_cs), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_done", 32'(o_done), 32'd0);
        chk("mid_rst_valid", 32'(o_pix_valid), 32'd0);
        chk("mid_rst_addr", 32'(o_addr), 32'd0);
        chk("mid_rst_pix", 32'({o_pix_col, o_pix_dat}), 32'd0);
        i_reset = 1'b0;
        n0 = cs_q.size();
        p0 = pix_q.size();
        repeat (6) step();
        chk("late_ack_cs", 32'(cs_q.size()), 32'(n0));
        chk("late_ack_pix", 32'(pix_q.size()), 32'(p0));
        chk("late_ack_done", 32'(done_q.size()), 32'd0);
        run_line(7, 9, 0, 0, 0);

        // Randomized rows (including out-of-range), scanlines, ready and ack latency.
        for (int t = 0; t < 6; t++)
            run_line(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)), 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
